sqrt_iter_ctrl: RTL

SQRT_ITER_CTRL -- requirements
Module: sqrt_iter_ctrl

---
 rtl/sqrt_iter_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/sqrt_iter_ctrl.sv
// Iterative integer square root controller.
//
// Computes o_root = floor(sqrt(i_data)) and o_remainder = i_data - o_root^2 using one
// non-restoring sqrt step per clock. A result takes ROOT_W step cycles plus one correction
// cycle. The result is then held in DONE until the downstream takes it.
//
// Ports:
//   i_clk, i_reset      clock and synchronous active-high reset
//   i_valid/o_ready     radicand handshake; i_data is the unsigned radicand
//   o_valid/i_ready     result handshake; o_root and o_remainder are the result
//   o_busy              high in every state except IDLE
module sqrt_iter_ctrl #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ROOT_W = DATA_W / 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [ROOT_W-1:0] o_root,
  output logic [ROOT_W:0]   o_remainder,
  output logic              o_busy
);

  localparam int unsigned CntW = (ROOT_W > 1) ? $clog2(ROOT_W) : 1;
  localparam int unsigned RemW = ROOT_W + 2;

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ROOT_W-1:0]   root_q, root_d;
  logic [RemW-1:0]     rem_q, rem_d;       // two's complement partial remainder
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [ROOT_W-1:0]   res_root_q, res_root_d;
  logic [ROOT_W:0]     res_rem_q, res_rem_d;

  logic                accept;
  logic [RemW-1:0]     rem_sh;
  logic [RemW-1:0]     rem_step;
  logic [RemW-1:0]     rem_fix;

  assign o_ready     = (state_q == StIdle) || ((state_q == StDone) && i_ready);
  assign accept      = i_valid && o_ready && !i_reset;
  assign o_valid     = (state_q == StDone);
  assign o_busy      = (state_q != StIdle);
  assign o_root      = res_root_q;
  assign o_remainder = res_rem_q;

  // One non-restoring step. The shifted value may wrap, but arithmetic is modular and the
  // sign decision uses the unshifted remainder, which always fits in RemW bits.
  always_comb begin
    rem_sh = {rem_q[ROOT_W-1:0], data_q[DATA_W-1 -: 2]};
    if (!rem_q[RemW-1]) begin
      rem_step = rem_sh - {root_q, 2'b01};
    end else begin
      rem_step = rem_sh + {root_q, 2'b11};
    end
    // A negative final remainder is restored by adding back 2*root+1.
    if (rem_q[RemW-1]) begin
      rem_fix = rem_q + {1'b0, root_q, 1'b1};
    end else begin
      rem_fix = rem_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    root_d     = root_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    res_root_d = res_root_q;
    res_rem_d  = res_rem_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StCalc;
          data_d  = i_data;
          root_d  = '0;
          rem_d   = '0;
          cnt_d   = CntW'(ROOT_W - 1);
        end
      end
      StCalc: begin
        data_d = data_q << 2;
        rem_d  = rem_step;
        root_d = {root_q[ROOT_W-2:0], ~rem_step[RemW-1]};
        if (cnt_q == '0) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StFix: begin
        res_root_d = root_q;
        res_rem_d  = rem_fix[ROOT_W:0];
        state_d    = StDone;
      end
      StDone: begin
        if (i_ready) begin
          if (accept) begin
            // Back-to-back: consume the result and start the next radicand.
            state_d = StCalc;
            data_d  = i_data;
            root_d  = '0;
            rem_d   = '0;
            cnt_d   = CntW'(ROOT_W - 1);
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= StIdle;
      data_q     <= '0;
      root_q     <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      res_root_q <= '0;
      res_rem_q  <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      root_q     <= root_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      res_root_q <= res_root_d;
      res_rem_q  <= res_rem_d;
    end
  end

endmodule
